// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage between fetch and execute. A main output register
// and an optional spill register let ready_o be registered without losing or repeating instructions.
module decode_stage #(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int SKID     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ins_i,
    input  logic [ADDR_W-1:0] ins_addr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic [31:0]       ins_o,
    output logic [ADDR_W-1:0] ins_addr_o,
    output logic [4:0]        rs1_addr_o,
    output logic [4:0]        rs2_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic [31:0]       imm_o,
    output logic              rs1_en_o,
    output logic              rs2_en_o,
    output logic              rd_we_o,
    output logic              illegal_o,
    output logic              valid_o,
    input  logic              ready_i
);

    typedef struct packed {
        logic [31:0]       ins;
        logic [ADDR_W-1:0] addr;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [31:0]       imm;
        logic              rs1_en;
        logic              rs2_en;
        logic              rd_we;
        logic              illegal;
    } dec_t;

    localparam logic [5:0] NR = 6'(NUM_REGS);

    dec_t        dec, main_q, main_n, spill_q, spill_n;
    logic        main_v, main_v_n, spill_v, spill_v_n, ready_q;
    logic        use1, use2, used, bad_op, bad_reg;
    logic [31:0] imm_raw;
    logic        in_xfer, out_xfer;

    always_comb begin
        use1    = 1'b0;
        use2    = 1'b0;
        used    = 1'b0;
        bad_op  = 1'b0;
        imm_raw = '0;
        case (ins_i[6:0])
            7'b0110111, 7'b0010111: begin
                used    = 1'b1;
                imm_raw = {ins_i[31:12], 12'b0};
            end
            7'b1101111: begin
                used    = 1'b1;
                imm_raw = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
                use1    = 1'b1;
                used    = 1'b1;
                imm_raw = {{20{ins_i[31]}}, ins_i[31:20]};
            end
            7'b0100011: begin
                use1    = 1'b1;
                use2    = 1'b1;
                imm_raw = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
            end
            7'b1100011: begin
                use1    = 1'b1;
                use2    = 1'b1;
                imm_raw = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
            end
            7'b0110011: begin
                use1   = 1'b1;
                use2   = 1'b1;
                used   = 1'b1;
                bad_op = (ins_i[31:25] != 7'h00) && (ins_i[31:25] != 7'h20);
            end
            default: bad_op = 1'b1;
        endcase
        // Only registers the format actually uses are range-checked (matters for RV32E).
        bad_reg = (use1 && ({1'b0, ins_i[19:15]} >= NR)) ||
                  (use2 && ({1'b0, ins_i[24:20]} >= NR)) ||
                  (used && ({1'b0, ins_i[11:7]}  >= NR));

        dec         = '0;
        dec.ins     = ins_i;
        dec.addr    = ins_addr_i;
        dec.illegal = bad_op | bad_reg;
        if (!dec.illegal) begin
            dec.rs1_en = use1;
            dec.rs2_en = use2;
            dec.rd_we  = used && (ins_i[11:7] != 5'd0);
            dec.rs1    = use1 ? ins_i[19:15] : 5'd0;
            dec.rs2    = use2 ? ins_i[24:20] : 5'd0;
            dec.rd     = used ? ins_i[11:7]  : 5'd0;
            dec.imm    = imm_raw;
        end
    end

    // Handshake: a beat moves on a side only in a cycle where that side's valid
    // and ready are both high; valid/data never change while stalled.
    assign ready_o  = (SKID != 0) ? ready_q : (ready_q & (!main_v | ready_i));
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = main_v & ready_i;

    always_comb begin
        main_n    = main_q;
        main_v_n  = main_v;
        spill_n   = spill_q;
        spill_v_n = spill_v;
        if (flush_i) begin
            main_v_n  = 1'b0;
            spill_v_n = 1'b0;
        end else if (!main_v) begin
            if (in_xfer) begin
                main_n   = dec;
                main_v_n = 1'b1;
            end
        end else if (out_xfer) begin
            // ready_o is low whenever the spill is full, so no input can arrive here then.
            if (spill_v) begin
                main_n    = spill_q;
                spill_v_n = 1'b0;
            end else if (in_xfer) begin
                main_n = dec;
            end else begin
                main_v_n = 1'b0;
            end
        end else if (in_xfer && SKID != 0) begin
            spill_n   = dec;
            spill_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            spill_q <= '0;
            main_v  <= 1'b0;
            spill_v <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            main_q  <= main_n;
            spill_q <= spill_n;
            main_v  <= main_v_n;
            spill_v <= spill_v_n;
            ready_q <= (SKID != 0) ? !spill_v_n : 1'b1;
        end
    end

    assign valid_o    = main_v;
    assign ins_o      = main_q.ins;
    assign ins_addr_o = main_q.addr;
    assign rs1_addr_o = main_q.rs1;
    assign rs2_addr_o = main_q.rs2;
    assign rd_addr_o  = main_q.rd;
    assign imm_o      = main_q.imm;
    assign rs1_en_o   = main_q.rs1_en;
    assign rs2_en_o   = main_q.rs2_en;
    assign rd_we_o    = main_q.rd_we;
    assign illegal_o  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage (RV32E, skid buffer): directed test-plan cases plus
// randomised traffic checked against an expected-result queue.
module tb_decode_stage;

    localparam int W = 115;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ins_i = '0;
    logic [31:0] ins_addr_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        flush_i = 1'b0;
    logic [31:0] ins_o;
    logic [31:0] ins_addr_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [31:0] imm_o;
    logic        rs1_en_o, rs2_en_o, rd_we_o, illegal_o, valid_o;
    logic        ready_i = 1'b1;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic rand_done = 1'b0;
    logic [31:0] addr_ctr = 32'h1000;

    decode_stage #(.ADDR_W(32), .NUM_REGS(16), .SKID(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
        .ins_o(ins_o), .ins_addr_o(ins_addr_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .imm_o(imm_o),
        .rs1_en_o(rs1_en_o), .rs2_en_o(rs2_en_o), .rd_we_o(rd_we_o),
        .illegal_o(illegal_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    wire [W-1:0] obs = {ins_o, ins_addr_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
                        imm_o, rs1_en_o, rs2_en_o, rd_we_o, illegal_o};

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode for a 16-register file.
    function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [31:0] addr);
        logic u1, u2, ud, ill;
        logic [31:0] imm;
        logic [4:0] rs1, rs2, rd;
        u1 = 0; u2 = 0; ud = 0; ill = 0; imm = 0;
        case (ins[6:0])
            7'h37, 7'h17: begin ud = 1; imm = {ins[31:12], 12'h000}; end
            7'h6F: begin ud = 1; imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin u1 = 1; ud = 1; imm = {{21{ins[31]}}, ins[30:20]}; end
            7'h23: begin u1 = 1; u2 = 1; imm = {{21{ins[31]}}, ins[30:25], ins[11:7]}; end
            7'h63: begin u1 = 1; u2 = 1; imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
            7'h33: begin u1 = 1; u2 = 1; ud = 1; ill = !(ins[31:25] == 7'h00 || ins[31:25] == 7'h20); end
            default: ill = 1;
        endcase
        if (u1 && ins[19]) ill = 1;
        if (u2 && ins[24]) ill = 1;
        if (ud && ins[11]) ill = 1;
        rs1 = (u1 && !ill) ? ins[19:15] : 5'd0;
        rs2 = (u2 && !ill) ? ins[24:20] : 5'd0;
        rd  = (ud && !ill) ? ins[11:7]  : 5'd0;
        if (ill) imm = 0;
        return {ins, addr, rs1, rs2, rd, imm, u1 & !ill, u2 & !ill, (rd != 0), ill};
    endfunction

    // Scoreboard: push on accepted input, pop on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o && ready_i) begin
                out_cnt++;
                if (exp_q.size() == 0) check("unexpected_out", obs, '1);
                else check("sb_out", obs, exp_q.pop_front());
            end
            if (flush_i) exp_q.delete();
            else if (valid_i && ready_o) exp_q.push_back(model(ins_i, ins_addr_i));
        end
    end

    task automatic drive_ins(input logic [31:0] ins);
        int n = 0;
        logic acc = 1'b0;
        ins_i = ins;
        ins_addr_i = addr_ctr;
        addr_ctr += 4;
        valid_i = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", {{(W-1){1'b0}}, acc}, 1);
        valid_i = 1'b0;
    endtask

    // Fields of the instruction that just entered an empty stage.
    task automatic check_fields(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] flags);
        check(tag, {valid_o, rs1_addr_o, rs2_addr_o, rd_addr_o, imm_o, rs1_en_o, rs2_en_o, rd_we_o, illegal_o},
              {1'b1, rs1, rs2, rd, imm, flags});
    endtask

    initial begin
        int base, n;
        logic [31:0] r;
        logic [6:0] ops [12];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33, 7'h5B};

        #1 rst_n = 1'b0;
        #2;
        check("reset_state", {valid_o, ready_o, obs}, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {{(W-1){1'b0}}, ready_o}, 1);

        drive_ins(32'hFFF10093);
        check_fields("addi", 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 4'b1010);
        drive_ins(32'hFE532E23);
        check_fields("sw", 5'd6, 5'd5, 5'd0, 32'hFFFFFFFC, 4'b1100);
        drive_ins(32'hFF9FF0EF);
        check_fields("jal", 5'd0, 5'd0, 5'd1, 32'hFFFFFFF8, 4'b0010);
        drive_ins(32'h00000000);
        check_fields("zero_ins", 5'd0, 5'd0, 5'd0, 32'h0, 4'b0001);
        drive_ins(32'h011000B3);
        check_fields("rv32e_x17", 5'd0, 5'd0, 5'd0, 32'h0, 4'b0001);
        drive_ins(32'h00000033);
        check_fields("add_x0", 5'd0, 5'd0, 5'd0, 32'h0, 4'b1100);

        // Back-pressure: two accepted then ready_o drops; all three drain in order.
        repeat (2) @(posedge clk);
        #1 ready_i = 1'b0;
        drive_ins(32'h00500113);
        drive_ins(32'h00A00193);
        check("bp_ready_low", {{(W-1){1'b0}}, ready_o}, 0);
        fork
            drive_ins(32'h00F00213);
            begin
                repeat (3) @(posedge clk);
                #1 ready_i = 1'b1;
                base = out_cnt;
                repeat (3) @(negedge clk);
                #1;
                check("bp_consecutive", W'(out_cnt - base), 3);
            end
        join
        repeat (3) @(posedge clk);

        // Flush with both registers full and a new instruction offered.
        #1 ready_i = 1'b0;
        drive_ins(32'h00100293);
        drive_ins(32'h00200313);
        ins_i = 32'h00300393;
        ins_addr_i = 32'hDEAD0000;
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_state", {{(W-2){1'b0}}, valid_o, ready_o}, 2'b01);
        base = out_cnt;
        ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("flush_no_out", W'(out_cnt - base), 0);

        // Random traffic with random back-pressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    r = $urandom();
                    r[6:0] = ops[$urandom_range(0, 11)];
                    if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom_range(0, 2));
                    if (r[6:0] == 7'h33 && $urandom_range(0, 1) == 1) r[31:25] = 7'h00;
                    drive_ins(r);
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 ready_i = ($urandom_range(0, 2) != 0);
                end
            end
        join
        ready_i = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", W'(exp_q.size()), 0);

        // Asynchronous reset while stalled with valid output.
        ready_i = 1'b0;
        drive_ins(32'h00700413);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {valid_o, ready_o, obs}, '0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst2", {{(W-1){1'b0}}, ready_o}, 1);
        ready_i = 1'b1;
        drive_ins(32'h00C28493);
        check_fields("post_reset_addi", 5'd5, 5'd0, 5'd9, 32'h0000000C, 4'b1010);
        repeat (3) @(posedge clk);
        #1;
        check("final_empty", W'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
